// File: rtl/fs_accel_mpgather_if.sv
// Lane-gatherer bus: per-lane result handshakes in, one serialised result stream out.
// The slave modport is the gatherer; the master modport is the lane/writeback side.
interface fs_accel_mpgather_if #(
  parameter int NUM_LANES = 13,
  parameter int DW        = 8
);
  logic [NUM_LANES-1:0]    lane_valid;
  logic [NUM_LANES*DW-1:0] lane_data;
  logic [NUM_LANES-1:0]    lane_ready;
  logic [DW-1:0]           dout;
  logic [3:0]              dout_sel;
  logic                    dout_valid;
  logic                    dout_last;
  logic                    dout_ready;

  modport master (
    output lane_valid, lane_data, dout_ready,
    input  lane_ready, dout, dout_sel, dout_valid, dout_last
  );

  modport slave (
    input  lane_valid, lane_data, dout_ready,
    output lane_ready, dout, dout_sel, dout_valid, dout_last
  );
endinterface

// File: rtl/fs_accel_mpgather.sv
// Max-pool lane gatherer: one buffered result per lane, re-serialised in lane order.
// Latency 2 cycles lane->dout; output register holds under dout_ready low, lanes stall via full flags.
module fs_accel_mpgather #(
  parameter int NUM_LANES = 13,
  parameter int DW        = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic [3:0]           cfg_lanes,
  output logic [15:0]          frame_cnt,
  fs_accel_mpgather_if.slave   bus
);

  logic [DW-1:0]        lane_buf_q [NUM_LANES];
  logic [NUM_LANES-1:0] full_q;
  logic [3:0]           lanes_q;
  logic [3:0]           ptr_q;
  logic [DW-1:0]        dout_q;
  logic [3:0]           sel_q;
  logic                 vld_q;
  logic                 last_q;
  logic [15:0]          frame_cnt_q;

  logic [NUM_LANES-1:0] lane_ready;
  logic [NUM_LANES-1:0] hs;
  logic [NUM_LANES-1:0] clr;
  logic                 load;
  logic [3:0]           cfg_sane;
  logic                 ptr_at_end;

  // Ready is purely registered state (plus reset) so lane_valid never loops back into it.
  always_comb begin
    lane_ready = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_ready[i] = !full_q[i] && (i < int'(lanes_q)) && resetn;
    end
  end

  assign hs         = bus.lane_valid & lane_ready;
  assign ptr_at_end = (ptr_q == lanes_q - 4'd1);
  assign load       = (!vld_q || bus.dout_ready) && full_q[ptr_q];
  assign clr        = load ? (NUM_LANES'(1) << ptr_q) : '0;
  assign cfg_sane   = (cfg_lanes == 4'd0 || cfg_lanes > 4'(NUM_LANES)) ? 4'(NUM_LANES) : cfg_lanes;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      full_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_buf_q[i] <= 8'h80;
      end
      ptr_q  <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      if (!resetn) begin
        lanes_q     <= 4'(NUM_LANES);
        frame_cnt_q <= '0;
        dout_q      <= 8'h80;
        sel_q       <= '0;
      end else begin
        lanes_q <= cfg_sane;
      end
    end else begin
      if (vld_q && bus.dout_ready && last_q) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (hs[i]) begin
          lane_buf_q[i] <= bus.lane_data[i*DW +: DW];
        end
      end
      // A lane being drained is full, hence not ready, so set and clear never collide.
      full_q <= (full_q | hs) & ~clr;
      if (load) begin
        dout_q <= lane_buf_q[ptr_q];
        sel_q  <= ptr_q;
        last_q <= ptr_at_end;
        vld_q  <= 1'b1;
        ptr_q  <= ptr_at_end ? 4'd0 : ptr_q + 4'd1;
      end else if (bus.dout_ready) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.lane_ready = lane_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_sel   = sel_q;
  assign bus.dout_valid = vld_q;
  assign bus.dout_last  = last_q;
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_fs_accel_mpgather.sv
// Directed bench for the max-pool lane gatherer: reset, ordering, backpressure, flush, extremes.
module tb_fs_accel_mpgather;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic [3:0]  cfg_lanes;
  logic [15:0] frame_cnt;

  fs_accel_mpgather_if bus ();

  fs_accel_mpgather dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .cfg_lanes (cfg_lanes),
    .frame_cnt (frame_cnt),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_d [$];
  logic [3:0] exp_s [$];
  logic       exp_l [$];

  logic [103:0] ld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [3:0] s, input logic l);
    exp_d.push_back(d);
    exp_s.push_back(s);
    exp_l.push_back(l);
  endtask

  // Samples at the current negedge first, so a word visible now is never missed.
  task automatic drain(input int max_cyc);
    int  cyc     = 0;
    bit  started = 1'b0;
    while (exp_d.size() > 0 && cyc < max_cyc) begin
      if (bus.dout_valid && bus.dout_ready) begin
        started = 1'b1;
        check("dout", 32'(bus.dout), 32'(exp_d.pop_front()));
        check("dout_sel", 32'(bus.dout_sel), 32'(exp_s.pop_front()));
        check("dout_last", 32'(bus.dout_last), 32'(exp_l.pop_front()));
      end else if (started) begin
        check("stream_gap", 32'(bus.dout_valid), 32'd1);
      end
      @(negedge clk);
      cyc++;
    end
    check("drain_left", 32'(exp_d.size()), 32'd0);
    exp_d.delete();
    exp_s.delete();
    exp_l.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    flush          = 1'b0;
    cfg_lanes      = 4'd0;
    bus.lane_valid = 13'h1FFF;
    bus.lane_data  = '0;
    bus.dout_ready = 1'b1;
    ld             = '0;

    // Reset held with every lane valid
    repeat (3) begin
      @(negedge clk);
      check("rst_dout", 32'(bus.dout), 32'h80);
      check("rst_vld", 32'(bus.dout_valid), 32'd0);
      check("rst_rdy", 32'(bus.lane_ready), 32'h0);
    end
    resetn         = 1'b1;
    bus.lane_valid = '0;
    @(negedge clk);
    check("post_rst_rdy", 32'(bus.lane_ready), 32'h1FFF);
    check("post_rst_frames", 32'(frame_cnt), 32'd0);

    // Full frame, data 3i-20
    for (int i = 0; i < 13; i++) begin
      ld[8*i +: 8] = 8'(3*i - 20);
      push(8'(3*i - 20), 4'(i), i == 12);
    end
    bus.lane_data  = ld;
    bus.lane_valid = 13'h1FFF;
    @(negedge clk);
    bus.lane_valid = '0;
    check("ff_latency", 32'(bus.dout_valid), 32'd0);
    check("ff_rdy_full", 32'(bus.lane_ready), 32'h0);
    drain(40);
    check("ff_frames", 32'(frame_cnt), 32'd1);
    check("ff_idle", 32'(bus.dout_valid), 32'd0);

    // Out-of-order arrival on a 3-lane frame
    flush     = 1'b1;
    cfg_lanes = 4'd3;
    @(negedge clk);
    flush = 1'b0;
    check("ooo_rdy", 32'(bus.lane_ready), 32'h0007);
    ld             = '0;
    ld[23:16]      = 8'h05;
    bus.lane_data  = ld;
    bus.lane_valid = 13'b100;
    @(negedge clk);
    check("ooo_wait2", 32'(bus.dout_valid), 32'd0);
    ld[15:8]       = 8'hF9;
    bus.lane_data  = ld;
    bus.lane_valid = 13'b010;
    @(negedge clk);
    check("ooo_wait1", 32'(bus.dout_valid), 32'd0);
    ld[7:0]        = 8'h7F;
    bus.lane_data  = ld;
    bus.lane_valid = 13'b001;
    @(negedge clk);
    bus.lane_valid = '0;
    check("ooo_wait0", 32'(bus.dout_valid), 32'd0);
    push(8'h7F, 4'd0, 1'b0);
    push(8'hF9, 4'd1, 1'b0);
    push(8'h05, 4'd2, 1'b1);
    drain(10);
    check("ooo_frames", 32'(frame_cnt), 32'd2);

    // Backpressure on a full frame; cfg_lanes 0 sanitises to 13
    flush     = 1'b1;
    cfg_lanes = 4'd0;
    @(negedge clk);
    flush = 1'b0;
    check("cfg0_rdy", 32'(bus.lane_ready), 32'h1FFF);
    bus.dout_ready = 1'b0;
    for (int i = 0; i < 13; i++) begin
      ld[8*i +: 8] = 8'(9*i - 60);
      push(8'(9*i - 60), 4'(i), i == 12);
    end
    bus.lane_data  = ld;
    bus.lane_valid = 13'h1FFF;
    @(negedge clk);
    bus.lane_valid = '0;
    repeat (5) begin
      @(negedge clk);
      check("bp_vld", 32'(bus.dout_valid), 32'd1);
      check("bp_sel", 32'(bus.dout_sel), 32'd0);
      check("bp_dout", 32'(bus.dout), 32'hC4);
      check("bp_rdy", 32'(bus.lane_ready & 13'h1FFE), 32'h0);
    end
    bus.dout_ready = 1'b1;
    drain(40);
    check("bp_frames", 32'(frame_cnt), 32'd3);

    // Flush after six words, reconfigure to 4 lanes
    for (int i = 0; i < 13; i++) begin
      ld[8*i +: 8] = 8'(60 - 10*i);
      if (i < 6) push(8'(60 - 10*i), 4'(i), 1'b0);
    end
    bus.lane_data  = ld;
    bus.lane_valid = 13'h1FFF;
    @(negedge clk);
    bus.lane_valid = '0;
    drain(20);
    flush     = 1'b1;
    cfg_lanes = 4'd4;
    @(negedge clk);
    flush = 1'b0;
    check("fl_vld", 32'(bus.dout_valid), 32'd0);
    check("fl_rdy", 32'(bus.lane_ready), 32'h000F);
    check("fl_frames", 32'(frame_cnt), 32'd3);
    for (int i = 0; i < 13; i++) begin
      ld[8*i +: 8] = 8'(11*i + 11);
    end
    for (int i = 0; i < 4; i++) begin
      push(8'(11*i + 11), 4'(i), i == 3);
    end
    bus.lane_data  = ld;
    bus.lane_valid = 13'h1FFF;
    @(negedge clk);
    bus.lane_valid = '0;
    drain(20);
    check("cfg4_frames", 32'(frame_cnt), 32'd4);
    check("cfg4_no_extra", 32'(bus.dout_valid), 32'd0);

    // Single lane, extreme values, frame counter wrap
    flush     = 1'b1;
    cfg_lanes = 4'd1;
    @(negedge clk);
    flush = 1'b0;
    check("l1_rdy", 32'(bus.lane_ready), 32'h0001);
    force dut.frame_cnt_q = 16'hFFFE;
    #1;
    release dut.frame_cnt_q;
    ld             = '0;
    ld[7:0]        = 8'h80;
    bus.lane_data  = ld;
    bus.lane_valid = 13'h0001;
    @(negedge clk);
    bus.lane_valid = '0;
    push(8'h80, 4'd0, 1'b1);
    drain(10);
    check("wrap_ffff", 32'(frame_cnt), 32'hFFFF);
    ld[7:0]        = 8'h7F;
    bus.lane_data  = ld;
    bus.lane_valid = 13'h0001;
    @(negedge clk);
    bus.lane_valid = '0;
    push(8'h7F, 4'd0, 1'b1);
    drain(10);
    check("wrap_0000", 32'(frame_cnt), 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
